// File: rtl/sub_serial.sv
// sub_serial: digit-serial subtractor computing o = g - e (mod 2^N).
// Operands arrive W bits per clock, LSB digit first. A single borrow
// flip-flop chains the digits, so one operation takes CC = N/W cycles
// and needs only W full-subtractor cells.
//
// Handshake: start is sampled only in IDLE and the digit 0 operands are
// taken on that same edge. Each later edge in RUN takes one more digit.
// start is ignored while busy. valid is a one-cycle pulse that marks the
// first cycle in which o/borrow_out carry a new result. A new start may be
// issued in the valid cycle. o/borrow_out hold their value until the next
// completion.
module sub_serial #(
  parameter int N = 8,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] g_input,
  input  logic [W-1:0] e_input,
  output logic [N-1:0] o,
  output logic         borrow_out,
  output logic         valid,
  output logic         busy
);

  localparam int CC = N / W;
  localparam int CW = $clog2(CC + 1);

  // Reject digit widths that do not evenly tile the operand.
  if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_bad_param
    $error("sub_serial: W must satisfy 1 <= W <= N and N mod W == 0");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_borrow;
  logic [N-1:0]   r_shift;

  logic           w_borrow_in;
  logic [W:0]     w_diff;
  logic [N+W-1:0] w_cat;
  logic [N-1:0]   w_shift_next;
  logic           w_take;
  logic           w_last;
  logic           w_unused;

  // The first digit of an operation never has an incoming borrow.
  assign w_borrow_in  = (r_state == S_RUN) ? r_borrow : 1'b0;
  // W-bit subtract; the extra top bit is the outgoing borrow.
  assign w_diff       = {1'b0, g_input} - {1'b0, e_input} - {{W{1'b0}}, w_borrow_in};
  // New digit enters at the MSB end, the register moves right by W.
  assign w_cat        = {w_diff[W-1:0], r_shift};
  assign w_shift_next = w_cat[N+W-1:W];
  // The lowest W bits fall off the end of the shift.
  assign w_unused     = ^w_cat[W-1:0];

  // A digit is consumed on an accepted start in IDLE and on every RUN edge.
  assign w_take = (r_state == S_IDLE) ? start : 1'b1;
  // Last digit: immediately when one digit covers the operand, else at CC-1.
  assign w_last = (r_state == S_IDLE) ? (CC == 1) : (r_cnt == CW'(CC - 1));

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_borrow   <= 1'b0;
      r_shift    <= '0;
      o          <= '0;
      borrow_out <= 1'b0;
      valid      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (w_take) begin
        r_shift <= w_shift_next;
        if (w_last) begin
          o          <= w_shift_next;
          borrow_out <= w_diff[W];
          valid      <= 1'b1;
          busy       <= 1'b0;
          r_state    <= S_IDLE;
          r_cnt      <= '0;
          r_borrow   <= 1'b0;
        end else begin
          r_borrow <= w_diff[W];
          r_cnt    <= r_cnt + CW'(1);
          r_state  <= S_RUN;
          busy     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: drives four sub_serial instances (N=8, W=1/2/4/8) and
// compares every completed operation with (g - e) mod 256 and g < e.
module tb_sub_serial;

  localparam int NI = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [NI-1:0] start_d;
  logic [7:0]    g_d [NI];
  logic [7:0]    e_d [NI];
  logic [7:0]    o_q [NI];
  logic [NI-1:0] bo_q;
  logic [NI-1:0] vld_q;
  logic [NI-1:0] bsy_q;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    sub_serial #(.N(8), .W(1 << k)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start_d[k]),
      .g_input    (g_d[k][(1 << k) - 1:0]),
      .e_input    (e_d[k][(1 << k) - 1:0]),
      .o          (o_q[k]),
      .borrow_out (bo_q[k]),
      .valid      (vld_q[k]),
      .busy       (bsy_q[k])
    );
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [8:0] exp_q[$];          // {borrow, result} per issued operation
  logic [7:0] last_o [NI];       // result each instance should be holding

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned arithmetic on whole operands.
  function automatic logic [8:0] ref_sub(input logic [7:0] g, input logic [7:0] e);
    int d;
    d = int'(g) - int'(e);
    return {(g < e), 8'(d & 255)};
  endfunction

  // Every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (vld_q[k] === 1'b1) begin
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected_valid_w%0d", 1 << k), 32'd1, 32'd0);
        end else begin
          logic [8:0] ex;
          ex = exp_q.pop_front();
          check($sformatf("o_w%0d", 1 << k), 32'(o_q[k]), 32'(ex[7:0]));
          check($sformatf("borrow_w%0d", 1 << k), 32'(bo_q[k]), 32'(ex[8]));
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge where valid must be visible.
  task automatic drive_op(input int k, input logic [7:0] g, input logic [7:0] e,
                          input bit spurious);
    int w;
    int cc;
    w  = 1 << k;
    cc = 8 / w;
    exp_q.push_back(ref_sub(g, e));
    for (int j = 0; j < cc; j++) begin
      if (j == 0) begin
        check($sformatf("busy_idle_w%0d", w), 32'(bsy_q[k]), 32'd0);
        start_d[k] = 1'b1;
      end else begin
        check($sformatf("busy_run_w%0d", w), 32'(bsy_q[k]), 32'd1);
        check($sformatf("valid_early_w%0d", w), 32'(vld_q[k]), 32'd0);
        check($sformatf("o_hold_w%0d", w), 32'(o_q[k]), 32'(last_o[k]));
        // start while busy must be ignored; drive a stray start on digit 1.
        start_d[k] = spurious && (j == 1);
      end
      g_d[k] = 8'(g >> (j * w));
      e_d[k] = 8'(e >> (j * w));
      @(negedge clk);
    end
    start_d[k] = 1'b0;
    g_d[k] = 8'($urandom);
    e_d[k] = 8'($urandom);
    check($sformatf("valid_done_w%0d", w), 32'(vld_q[k]), 32'd1);
    check($sformatf("busy_done_w%0d", w), 32'(bsy_q[k]), 32'd0);
    last_o[k] = 8'(g - e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] rg;
    logic [7:0] re;
    int         rk;
    rst     = 1'b0;
    start_d = '0;
    for (int k = 0; k < NI; k++) begin
      g_d[k]    = '0;
      e_d[k]    = '0;
      last_o[k] = '0;
    end
    idle(2);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_o_w%0d", 1 << k), 32'(o_q[k]), 32'd0);
      check($sformatf("rst_flags_w%0d", 1 << k),
            32'({bo_q[k], vld_q[k], bsy_q[k]}), 32'd0);
    end
    rst = 1'b1;
    idle(2);

    // Directed W=1 cases.
    drive_op(0, 8'h35, 8'h12, 1'b0);
    idle(2);
    drive_op(0, 8'h5A, 8'h5A, 1'b0);
    idle(1);
    drive_op(0, 8'h00, 8'h01, 1'b0);
    idle(2);

    // Asynchronous reset in the middle of a run, at digit 4.
    for (int j = 0; j < 4; j++) begin
      start_d[0] = (j == 0);
      g_d[0] = 8'(8'hFF >> j);
      e_d[0] = 8'(8'h00 >> j);
      @(negedge clk);
    end
    start_d[0] = 1'b0;
    check("busy_before_abort", 32'(bsy_q[0]), 32'd1);
    check("o_before_abort", 32'(o_q[0]), 32'hFF);
    rst = 1'b0;
    #1;
    check("abort_o", 32'(o_q[0]), 32'd0);
    check("abort_borrow", 32'(bo_q[0]), 32'd0);
    check("abort_valid", 32'(vld_q[0]), 32'd0);
    check("abort_busy", 32'(bsy_q[0]), 32'd0);
    #3;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) last_o[k] = '0;
    idle(10);   // long enough that a surviving run would have completed
    check("abort_still_idle", 32'(bsy_q[0]), 32'd0);
    drive_op(0, 8'h80, 8'h01, 1'b0);
    idle(2);

    // W=4: digits (7,C) then (A,5).  W=8: single-cycle operation.
    drive_op(2, 8'hA7, 8'h5C, 1'b0);
    idle(1);
    drive_op(3, 8'h10, 8'h20, 1'b0);
    idle(1);

    // Stray start mid-operation, then back-to-back start in the valid cycle.
    drive_op(0, 8'hC3, 8'h4E, 1'b1);
    drive_op(0, 8'h01, 8'h02, 1'b0);
    drive_op(1, 8'h9D, 8'hE0, 1'b1);
    drive_op(1, 8'h77, 8'h11, 1'b0);
    drive_op(3, 8'h05, 8'h06, 1'b0);
    drive_op(3, 8'hFF, 8'h00, 1'b0);
    idle(2);

    // Random regression across all digit widths, with back-to-back starts.
    for (int n = 0; n < 10000; n++) begin
      rk = $urandom_range(0, NI - 1);
      rg = 8'($urandom);
      re = ($urandom_range(0, 15) == 0) ? rg : 8'($urandom);
      drive_op(rk, rg, re, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(3);
    check("outstanding_ops", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sub_serial.md
Name: sub_serial

Overview:
- Multi-cycle digit-serial subtractor: o = g - e (mod 2^N) for N-bit operands, processed W bits per clock, LSB digit first.
- A borrow flip-flop chains the digits between cycles.
- Sequential counterpart to the single-cycle sum netlists. It lets the garbled-circuit flow evaluate subtraction in CC = N/W clock cycles with only W full-subtractor cells.
- A start/valid handshake frames each operation.

Parameters:
- N, 8, total operand/result width in bits.
- W, 1, digit width consumed per clock. N mod W must be 0 and 1 <= W <= N; otherwise the module raises an elaboration error.
- CC (localparam), N/W, number of digit cycles per operation.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- start  input  1  begin an operation; digit 0 is sampled on the same edge. Ignored unless IDLE.
- g_input  input  W  minuend digit for the current cycle.
- e_input  input  W  subtrahend digit for the current cycle.
- o  output  N  registered result; updated only on completion, held until the next completion.
- borrow_out  output  1  final borrow, i.e. 1 iff g < e unsigned; updated with o.
- valid  output  1  one-cycle pulse in the cycle o/borrow_out first show a new result.
- busy  output  1  1 while in RUN.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, borrow=0, shift register=0, o=0, borrow_out=0, valid=0, busy=0. All outputs are registered.
- States are IDLE and RUN. cnt is a ceil(log2(CC+1))-bit digit counter.
- IDLE with start=1:
  - Compute diff = g_input - e_input - 0 (W+1 bits).
  - Shift diff[W-1:0] into the MSB end of the internal N-bit shift register (right shift by W).
  - borrow <= diff[W].
  - If CC=1: complete now. Otherwise cnt <= 1, state <= RUN, busy <= 1.
- RUN, each edge:
  - Sample digit cnt: diff = g_input - e_input - borrow, shift and latch borrow as above.
  - If cnt==CC-1: complete. Otherwise cnt <= cnt+1.
- Complete (same edge as the last digit):
  - o <= {diff[W-1:0], shift_reg[N-1:W]}.
  - borrow_out <= diff[W], valid <= 1, busy <= 0, state <= IDLE, cnt <= 0, borrow <= 0.
- valid deasserts on the following edge unless another completion occurs there.
- Latency: digit k is sampled on the k-th edge after and including the start edge. valid/o appear after the edge that samples digit CC-1, i.e. CC edges after start is sampled.
- start while busy: ignored; the operation in flight is unaffected.
- Back-to-back: start may be high in the valid cycle (state is IDLE) and is accepted. o keeps the old result until the new completion.
- Inputs g_input/e_input are don't-care outside sampled cycles.
- Reset mid-operation: aborts immediately, all state cleared, no valid pulse. start after rst release behaves normally.
- Arithmetic is modulo 2^N. The borrow chain is exactly equivalent to an N-bit ripple subtractor. No signed interpretation; signed callers use o directly and ignore borrow_out.

Test Plan:
- N=8, W=1: g=0x35, e=0x12 streamed LSB first after start -> valid pulses once, 8 edges after start; o=0x23, borrow_out=0, busy high exactly 7 cycles.
- N=8, W=1: g=0x00, e=0x01 -> o=0xFF, borrow_out=1; equal operands 0x5A-0x5A -> o=0x00, borrow_out=0.
- N=8, W=4 (CC=2): digits (7,C) then (A,5) -> o=0x4B, borrow_out=0 after 2 edges. Also the W=8 (CC=1) case: 0x10-0x20 -> o=0xF0, borrow_out=1, valid on the edge after start.
- start re-asserted mid-operation with different data -> ignored; result equals the first operation. Then start in the valid cycle -> second result after CC more edges, o stable in between.
- rst driven low for half a cycle at digit 4 of an 8-cycle run -> o=0, borrow_out=0, valid=0, busy=0 asynchronously; no valid pulse. A fresh 0x80-0x01 run then gives o=0x7F, borrow_out=0.
- Random regression (10k ops, W in {1,2,4,8}) against a reference model of (g-e) mod 256 and g<e, including back-to-back starts.
